// File: rtl/shift4_feeder.sv
// ============================================================================
// Module   : shift4_feeder
// Brief    : Feeds buffered parallel words into a 4-bit load/shift register,
//            one load cycle followed by SIZE shift-enable cycles per word.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift4_feeder #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            in_valid,
  input  logic [SIZE-1:0] in_data,
  output logic            in_ready,
  input  logic            hold,
  output logic            load,
  output logic            ena,
  output logic [SIZE-1:0] data,
  output logic            busy,
  output logic            word_done
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [SIZE-1:0]      r_mem [DEPTH];
  logic [c_PTR_W:0]     r_wr_ptr;
  logic [c_PTR_W:0]     r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_last;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = (r_state == ST_LOAD);
  assign w_last  = (r_cnt == c_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_PTR_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt   <= c_CNT_W'(SIZE);
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!hold) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_last) begin
              r_state <= w_empty ? ST_IDLE : ST_LOAD;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  assign in_ready  = !w_full;
  assign load      = (r_state == ST_LOAD);
  assign ena       = (r_state == ST_SHIFT) && !hold;
  assign word_done = ena && w_last;
  assign data      = load ? r_mem[r_rd_ptr[c_PTR_W-1:0]] : '0;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_shift4_feeder.sv
// ============================================================================
// Module   : tb_shift4_feeder
// Brief    : Self-checking bench for shift4_feeder with a downstream Shift4 model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift4_feeder;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       hold = 1'b0;
  logic       in_ready;
  logic       load;
  logic       ena;
  logic [3:0] data;
  logic       busy;
  logic       word_done;

  shift4_feeder #(.SIZE(4), .DEPTH(2)) dut (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .hold      (hold),
    .load      (load),
    .ena       (ena),
    .data      (data),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ena_run = 0;

  logic [3:0] exp_words[$];
  bit         exp_bits[$];
  logic [3:0] q_model;
  logic [3:0] mon_w;
  bit         mon_b;

  always @(posedge clk) cyc++;

  // Downstream Shift4: parallel load, right shift with zero fill.
  always @(posedge clk or posedge areset) begin
    if (areset)    q_model <= 4'h0;
    else if (load) q_model <= data;
    else if (ena)  q_model <= {1'b0, q_model[3:1]};
  end

  always @(posedge areset) ena_run = 0;

  always @(negedge clk) begin
    if (!areset) begin
      checks++;
      if (load && ena) begin
        errors++;
        $display("FAIL overlap: load=%b ena=%b, required not both high", load, ena);
      end
      if (load) begin
        checks++;
        if (exp_words.size() == 0) begin
          errors++;
          $display("FAIL sb_load: load with data=%h, required no load (queue empty)", data);
        end else begin
          mon_w = exp_words.pop_front();
          if (data !== mon_w) begin
            errors++;
            $display("FAIL sb_data: data=%h, required %h", data, mon_w);
          end
          for (int i = 0; i < 4; i++) exp_bits.push_back(mon_w[i]);
        end
        ena_run = 0;
      end
      if (ena) begin
        ena_run++;
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL sb_ena: ena with no pending bits, required ena=0");
        end else begin
          mon_b = exp_bits.pop_front();
          if (q_model[0] !== mon_b) begin
            errors++;
            $display("FAIL sb_bit: serial out=%b, required %b", q_model[0], mon_b);
          end
        end
      end
      if (word_done) begin
        checks++;
        if (!ena || ena_run != 4) begin
          errors++;
          $display("FAIL done_count: ena=%b shifts=%0d, required ena=1 shifts=4", ena, ena_run);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return load;
      1:       return word_done;
      2:       return ena;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output int at);
    int n = 0;
    at = -1;
    while (at < 0 && n < budget) begin
      if (sig(which)) at = cyc;
      else begin
        tick();
        n++;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: signal %0d not seen in %0d cycles, required seen", which, budget);
    end
  endtask

  task automatic push_word(input logic [3:0] w, output int acc);
    in_valid = 1'b1;
    in_data  = w;
    acc = -1;
    for (int n = 0; n < 40 && acc < 0; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_words.push_back(w);
        @(posedge clk);
        #1;
        acc = cyc;
      end
    end
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %h not accepted, required accepted", w);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({load, ena, word_done, busy, data} !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: %b, required 00000000", {load, ena, word_done, busy, data});
    end
    @(posedge clk);
    #1;
    areset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rel: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({load, ena, busy} !== 3'b000) begin
        errors++;
        $display("FAIL idle_quiet: load/ena/busy=%b, required 000", {load, ena, busy});
      end
    end
  endtask

  task automatic test_single;
    int a;
    push_word(4'b1011, a);
    checks++;
    if (load !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_c1: load=%b busy=%b, required 0 1", load, busy);
    end
    tick();
    checks++;
    if (load !== 1'b1 || data !== 4'b1011) begin
      errors++;
      $display("FAIL single_load: load=%b data=%b, required 1 1011", load, data);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ena !== 1'b1 || word_done !== (k == 3)) begin
        errors++;
        $display("FAIL single_shift%0d: ena=%b done=%b, required 1 %b", k, ena, word_done, k == 3);
      end
    end
    tick();
    checks++;
    if ({load, ena, busy} !== 3'b000 || q_model !== 4'b0000) begin
      errors++;
      $display("FAIL single_end: load/ena/busy=%b q=%b, required 000 0000", {load, ena, busy}, q_model);
    end
  endtask

  task automatic test_back_to_back;
    int a1, a2, l1, d1, d2;
    push_word(4'hA, a1);
    push_word(4'h5, a2);
    checks++;
    if (a2 !== a1 + 1) begin
      errors++;
      $display("FAIL b2b_push: second accept cycle %0d, required %0d", a2, a1 + 1);
    end
    wait_sig(0, 10, l1);
    checks++;
    if (l1 !== a1 + 1) begin
      errors++;
      $display("FAIL b2b_load1: cycle %0d, required %0d", l1, a1 + 1);
    end
    wait_sig(1, 10, d1);
    checks++;
    if (d1 !== l1 + 4) begin
      errors++;
      $display("FAIL b2b_done1: cycle %0d, required %0d", d1, l1 + 4);
    end
    tick();
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: load=%b after first done, required 1", load);
    end
    wait_sig(1, 10, d2);
    checks++;
    if (d2 - l1 !== 9) begin
      errors++;
      $display("FAIL b2b_span: %0d cycles load-to-done, required 10", d2 - l1 + 1);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_full;
    int a1, a2, a3, idle;
    push_word(4'h3, a1);
    push_word(4'hC, a2);
    in_data = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b0 || load !== 1'b1) begin
      errors++;
      $display("FAIL full_ready: in_ready=%b load=%b, required 0 1", in_ready, load);
    end
    push_word(4'h6, a3);
    checks++;
    if (a3 !== a2 + 2) begin
      errors++;
      $display("FAIL full_accept: third accepted at %0d, required %0d", a3, a2 + 2);
    end
    wait_sig(3, 40, idle);
    checks++;
    if (exp_words.size() !== 0) begin
      errors++;
      $display("FAIL full_drain: %0d words unloaded, required 0", exp_words.size());
    end
  endtask

  task automatic test_hold;
    int a, l, d;
    push_word(4'h9, a);
    wait_sig(0, 10, l);
    tick();
    tick();
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ena !== 1'b0 || word_done !== 1'b0) begin
        errors++;
        $display("FAIL hold_freeze%0d: ena=%b done=%b, required 0 0", i, ena, word_done);
      end
      tick();
    end
    hold = 1'b0;
    #1;
    checks++;
    if (ena !== 1'b1) begin
      errors++;
      $display("FAIL hold_resume: ena=%b, required 1", ena);
    end
    wait_sig(1, 10, d);
    checks++;
    if (d !== l + 7) begin
      errors++;
      $display("FAIL hold_delay: done at %0d, required %0d", d, l + 7);
    end
    tick();
  endtask

  task automatic test_hold_idle;
    int a, l, d;
    hold = 1'b1;
    push_word(4'h6, a);
    wait_sig(0, 10, l);
    checks++;
    if (l !== a + 1) begin
      errors++;
      $display("FAIL holdidle_load: load at %0d, required %0d", l, a + 1);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ena !== 1'b0) begin
        errors++;
        $display("FAIL holdidle_ena%0d: ena=%b, required 0", i, ena);
      end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (ena !== 1'b1) begin
      errors++;
      $display("FAIL holdidle_resume: ena=%b, required 1", ena);
    end
    wait_sig(1, 10, d);
    checks++;
    if (d !== l + 5) begin
      errors++;
      $display("FAIL holdidle_done: done at %0d, required %0d", d, l + 5);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int a, e;
    push_word(4'h2, a);
    push_word(4'h7, a);
    wait_sig(2, 10, e);
    @(negedge clk);
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if ({load, ena, word_done, busy, data} !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_out: %b in_ready=%b, required 00000000 1",
               {load, ena, word_done, busy, data}, in_ready);
    end
    exp_words.delete();
    exp_bits.delete();
    @(posedge clk);
    #1;
    areset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_rel: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({load, ena} !== 2'b00) begin
        errors++;
        $display("FAIL midreset_quiet: load/ena=%b, required 00", {load, ena});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_hold();
    test_hold_idle();
    test_reset_mid();
    checks++;
    if (exp_words.size() !== 0 || exp_bits.size() !== 0) begin
      errors++;
      $display("FAIL final_sb: words=%0d bits=%0d pending, required 0 0",
               exp_words.size(), exp_bits.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
